// File: rtl/hazard_fwd_unit_gen.sv
// Hazard detection and operand bypass control for the ID stage.
// It covers N producer stages and adds mul/div occupancy stalls and saturating performance counters.
module hazard_fwd_unit_gen #(
   parameter  int NSTG       = 2,
   parameter  int AW         = 5,
   parameter  int LOAD_STAGE = 1,
   parameter  int MD_LAT     = 4,
   parameter  int CNT_W      = 32,
   localparam int SW         = $clog2(2*NSTG+1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 r1_used,
   input  logic                 r2_used,
   input  logic [AW-1:0]        r1_in,
   input  logic [AW-1:0]        r2_in,
   input  logic [NSTG*AW-1:0]   stg_wreg,
   input  logic [NSTG-1:0]      stg_regwrite,
   input  logic [NSTG-1:0]      stg_memtoreg,
   input  logic                 id_md_op,
   input  logic                 id_hilo_rd,
   input  logic                 flush,
   input  logic                 clr_cnt,
   output logic [SW-1:0]        fwd_sel_a,
   output logic [SW-1:0]        fwd_sel_b,
   output logic                 stall,
   output logic                 load_use,
   output logic                 md_busy,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     fwd_cnt
);

   localparam int MDW = $clog2(MD_LAT+1);

   typedef enum logic {IDLE, BUSY} md_state_t;

   md_state_t        state_q, state_d;
   logic [MDW-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;

   logic [NSTG-1:0]  match_a, match_b;
   logic [SW:0]      res_a, res_b;
   logic             md_stall, issue;

   generate
      for (genvar gi = 0; gi < NSTG; gi++) begin : g_match
         assign match_a[gi] = r1_used & (r1_in != '0) & stg_regwrite[gi]
                            & (stg_wreg[gi*AW +: AW] == r1_in);
         assign match_b[gi] = r2_used & (r2_in != '0) & stg_regwrite[gi]
                            & (stg_wreg[gi*AW +: AW] == r2_in);
      end
   endgenerate

   // Returns {load_use, select}; scanning oldest to youngest lets the youngest match win.
   function automatic logic [SW:0] resolve(input logic [NSTG-1:0] m,
                                           input logic [NSTG-1:0] mtr);
      logic [SW:0] r;
      r = '0;
      for (int k = NSTG-1; k >= 0; k--) begin
         if (m[k]) begin
            if (!mtr[k])
               r = {1'b0, SW'(2*k+1)};
            else if (k >= LOAD_STAGE)
               r = {1'b0, SW'(2*k+2)};
            else
               r = {1'b1, {SW{1'b0}}};
         end
      end
      return r;
   endfunction

   always_comb begin
      res_a = resolve(match_a, stg_memtoreg);
      res_b = resolve(match_b, stg_memtoreg);
   end

   assign fwd_sel_a = res_a[SW-1:0];
   assign fwd_sel_b = res_b[SW-1:0];
   assign load_use  = res_a[SW] | res_b[SW];
   assign md_busy   = (state_q == BUSY);
   assign md_stall  = md_busy & (id_md_op | id_hilo_rd);
   assign stall     = load_use | md_stall;
   assign issue     = id_md_op & ~stall & ~flush;
   assign stall_cnt = stall_cnt_q;
   assign fwd_cnt   = fwd_cnt_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (issue) begin
               state_d = BUSY;
               cnt_d   = MDW'(MD_LAT);
            end
         end
         BUSY: begin
            cnt_d = cnt_q - MDW'(1);
            if (cnt_q == MDW'(1))
               state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      fwd_cnt_d   = fwd_cnt_q;
      if (clr_cnt) begin
         stall_cnt_d = '0;
         fwd_cnt_d   = '0;
      end else begin
         if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         if (!stall && ((fwd_sel_a != '0) || (fwd_sel_b != '0)) && (fwd_cnt_q != '1))
            fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         stall_cnt_q <= '0;
         fwd_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
         fwd_cnt_q   <= fwd_cnt_d;
      end
   end

endmodule
